// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB memory slave: FSM state encoding,
// the address decode result and the byte-offset helper.
package apb_mem_pkg;

  // Widest paddr the decode helper accepts.
  localparam int APB_MEM_MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_mem_state_t;

  typedef struct packed {
    logic [31:0] index;
    logic        err;
  } apb_mem_dec_t;

  // Number of byte-address bits below the word index (OFS).
  function automatic int apb_mem_ofs(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Word index plus error flag (index out of range or misaligned address).
  function automatic apb_mem_dec_t apb_mem_decode(
    input logic [APB_MEM_MAX_ADDR_W-1:0] addr,
    input int                            ofs,
    input int                            depth
  );
    apb_mem_dec_t                  dec;
    logic [APB_MEM_MAX_ADDR_W-1:0] idx;
    logic [APB_MEM_MAX_ADDR_W-1:0] lsb_mask;
    idx       = addr >> ofs;
    lsb_mask  = (64'd1 << ofs) - 64'd1;
    dec.index = idx[31:0];
    dec.err   = (idx >= 64'(depth)) || ((addr & lsb_mask) != '0);
    return dec;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word-organised storage for the APB memory slave: synchronous clear,
// byte-enable write port and combinational read of the indexed word.
module apb_mem_array #(
  parameter  int DEPTH  = 32,
  parameter  int DATA_W = 32,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              we,
  input  logic [STRB_W-1:0] be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Merge the enabled bytes of the write data into the addressed word.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (be[b]) mem_d[idx][b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end

  // Storage update; reset clears every word.
  // NOTE: this memory is deliberately reset because software relies on
  // reading zeros after reset; that forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave with word-addressed register memory, programmable wait states
// and error response. Define APB_MEM_PSTRB_EN to add the pstrb port and
// byte-strobe writes; without it every write updates the full word.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_MEM_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int OFS    = apb_mem_ofs(DATA_W);
  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(DEPTH);

  apb_mem_state_t    state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;

  apb_mem_dec_t      dec;
  logic [IDX_W-1:0]  idx;
  logic [STRB_W-1:0] wr_be;
  logic [DATA_W-1:0] rd_data;
  logic              mem_we;

  assign dec = apb_mem_decode(APB_MEM_MAX_ADDR_W'(paddr), OFS, DEPTH);
  assign idx = dec.index[IDX_W-1:0];

`ifdef APB_MEM_PSTRB_EN
  assign wr_be = pstrb;
`else
  assign wr_be = '1;
`endif

  apb_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (pclk),
    .clr_n (presetn),
    .we    (mem_we),
    .be    (wr_be),
    .idx   (idx),
    .wdata (pwdata),
    .rdata (rd_data)
  );

  // Transfer sequencing: setup -> wait-state countdown -> one-cycle response.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          wcnt_d  = 4'(WAIT_CYCLES);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - 4'd1;
          end else begin
            pready_d = 1'b1;
            state_d  = RESP;
            if (dec.err) begin
              prdata_d  = '0;
              pslverr_d = 1'b1;
            end else if (pwrite) begin
              mem_we = 1'b1;
            end else begin
              prdata_d = rd_data;
            end
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered bus outputs; reset overrides any in-flight transfer.
  // NOTE: non-blocking assignments here so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (0 and 3 wait states) on one APB
// segment with separate psel lines. A master task issues transfers and pushes
// the expected response from a reference model; a monitor pops and compares
// whenever a slave raises pready.
module tb_apb_mem_slave;

  localparam int DEPTH = 32;
  localparam int W0    = 0;
  localparam int W1    = 3;

  typedef struct {
    int          dut;
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [1:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1;
  logic        pslverr0, pslverr1;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] last_rd [2];

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel[0]),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
`ifdef APB_MEM_PSTRB_EN
    .pstrb   (pstrb),
`endif
    .prdata  (prdata0),
    .pready  (pready0),
    .pslverr (pslverr0)
  );

  apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel[1]),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
`ifdef APB_MEM_PSTRB_EN
    .pstrb   (pstrb),
`endif
    .prdata  (prdata1),
    .pready  (pready1),
    .pslverr (pslverr1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic ready_of(input int d);
    return (d == 0) ? pready0 : pready1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[d][i] = '0;
    end
  endtask

  // One complete APB transfer; call at posedge+1, returns at posedge+1.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    exp_t       e;
    int         idx;
    logic       err;
    logic [3:0] eff;
    int         n;
    idx = int'(addr / 4);
    err = (addr % 4 != 0) || (addr / 4 >= DEPTH);
`ifdef APB_MEM_PSTRB_EN
    eff = strb;
`else
    eff = 4'hF;
`endif
    e.dut = d;
    e.cyc = cyc + ((d == 0) ? W0 : W1) + 2;
    e.err = err;
    if (err) begin
      e.data = '0;
      last_rd[d] = '0;
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (eff[b]) mem_m[d][idx][b*8 +: 8] = data[b*8 +: 8];
      e.data = last_rd[d];
    end else begin
      e.data = mem_m[d][idx];
      last_rd[d] = e.data;
    end
    sb.push_back(e);
    psel      = 2'b00;
    psel[d]   = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = addr;
    pwdata    = data;
    pstrb     = strb;
    @(posedge pclk);
    #1 penable = 1'b1;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!ready_of(d) && n < 40);
    if (!ready_of(d)) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout dut=%0d addr=0x%08h actual=no_pready required=pready", d, addr);
      sb.delete();
    end
    @(posedge pclk);
    #1;
    psel    = 2'b00;
    penable = 1'b0;
  endtask

  // Response monitor: compare every pready pulse against the scoreboard.
  always @(negedge pclk) begin
    for (int d = 0; d < 2; d++) begin
      logic        r, e;
      logic [31:0] dt;
      exp_t        x;
      r  = (d == 0) ? pready0 : pready1;
      e  = (d == 0) ? pslverr0 : pslverr1;
      dt = (d == 0) ? prdata0 : prdata1;
      if (r) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pready dut=%0d actual=1 expected=0 (cyc=%0d)", d, cyc);
        end else begin
          x = sb.pop_front();
          check($sformatf("resp_dut%0d", d), 32'(d), 32'(x.dut));
          check($sformatf("pready_cycle_dut%0d", d), 32'(cyc), 32'(x.cyc));
          check($sformatf("prdata_dut%0d", d), dt, x.data);
          check($sformatf("pslverr_dut%0d", d), 32'(e), 32'(x.err));
        end
      end else begin
        check($sformatf("pslverr_idle_dut%0d", d), 32'(e), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    presetn = 1'b0;
    psel    = 2'b00;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    model_reset();
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    @(negedge pclk);
    check("rst_prdata0", prdata0, 32'd0);
    check("rst_pready0", 32'(pready0), 32'd0);
    check("rst_pslverr0", 32'(pslverr0), 32'd0);
    check("rst_prdata1", prdata1, 32'd0);
    check("rst_pready1", 32'(pready1), 32'd0);
    @(posedge pclk);
    #1;

    // Defaults, write/read at 0 and 3 wait states.
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
    apb_xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0);
    apb_xfer(1, 1'b1, 32'h0C, 32'hA5A5_5A5A, 4'hF);
    apb_xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0);

    // Errors and boundaries.
    apb_xfer(0, 1'b1, 32'h80, 32'h55, 4'hF);
    apb_xfer(0, 1'b0, 32'h80, 32'h0, 4'h0);
    apb_xfer(0, 1'b0, 32'h02, 32'h0, 4'h0);
    apb_xfer(0, 1'b1, 32'h7C, 32'h0BAD_F00D, 4'hF);
    apb_xfer(0, 1'b0, 32'h7C, 32'h0, 4'h0);
    apb_xfer(1, 1'b0, 32'h81, 32'h0, 4'h0);

    // Byte strobes (full-word writes when the strobe feature is absent).
    apb_xfer(0, 1'b1, 32'h04, 32'h11223344, 4'hF);
    apb_xfer(0, 1'b1, 32'h04, 32'hAABBCCDD, 4'b0101);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0);
    apb_xfer(0, 1'b1, 32'h04, 32'hFFFF_FFFF, 4'b0000);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0);

    // Abort: drop psel during a 3-wait-state write.
    psel    = 2'b10;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h20;
    pwdata  = 32'hCAFE_F00D;
    pstrb   = 4'hF;
    @(posedge pclk);
    #1 penable = 1'b1;
    @(posedge pclk);
    #1;
    psel    = 2'b00;
    penable = 1'b0;
    repeat (6) @(posedge pclk);
    #1;
    apb_xfer(1, 1'b0, 32'h20, 32'h0, 4'h0);

    // Reset during the access phase of a write.
    psel    = 2'b01;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h30;
    pwdata  = 32'h1234_5678;
    pstrb   = 4'hF;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    presetn = 1'b0;
    @(posedge pclk);
    #1;
    presetn = 1'b1;
    psel    = 2'b00;
    penable = 1'b0;
    model_reset();
    @(negedge pclk);
    check("midrst_pready0", 32'(pready0), 32'd0);
    check("midrst_prdata0", prdata0, 32'd0);
    @(posedge pclk);
    #1;
    apb_xfer(0, 1'b0, 32'h30, 32'h0, 4'h0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0);
    apb_xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0);

    // Randomized traffic, including back-to-back and idle gaps.
    for (int k = 0; k < 200; k++) begin
      int          d;
      logic        wr;
      logic [31:0] a;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 35)) * 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      apb_xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge pclk);
        #1;
      end
    end

    repeat (4) @(posedge pclk);
    @(negedge pclk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave.md
# apb_mem_slave

Parametrised APB slave with word-addressed register memory, programmable wait states, error response and optional byte-strobe writes. It is the next-generation peripheral-side memory target on the APB bus segment. A single instance serves one `psel` line behind the bus decoder.

## Interface
Parameters:
- `ADDR_W`, default 32: `paddr` width.
- `DATA_W`, default 32: data width. Legal values are 8, 16, 32 and 64.
- `DEPTH`, default 32: number of memory words. Must be at least 2.
- `WAIT_CYCLES`, default 0: extra access-phase cycles inserted before `pready`. Range is 0 to 15.

Ports:
- `pclk` input 1: clock. All logic is on the rising edge.
- `presetn` input 1: reset, synchronous and active-low.
- `psel` input 1: slave select.
- `penable` input 1: access-phase indicator.
- `pwrite` input 1: 1 = write, 0 = read.
- `paddr` input ADDR_W: byte address.
- `pwdata` input DATA_W: write data.
- `pstrb` input DATA_W/8: byte write strobes. Present only when `APB_MEM_PSTRB_EN` is defined.
- `prdata` output DATA_W: read data. Valid while `pready`=1.
- `pready` output 1: transfer complete. Registered.
- `pslverr` output 1: error response. Valid only while `pready`=1, otherwise 0.

## Operation
- Address decode:
  - `OFS = log2(DATA_W/8)`.
  - Word index = `paddr[ADDR_W-1:OFS]`.
  - Error when index >= DEPTH, or when `paddr[OFS-1:0]` != 0 (misaligned).
- States are IDLE, WAIT, RESP.
- IDLE:
  - `pready`=0 and `pslverr`=0.
  - On `psel`=1 & `penable`=0: load `wcnt` <= WAIT_CYCLES, go to WAIT.
- WAIT:
  - If `psel`=0, go to IDLE (abort). No memory effect.
  - Else if `penable`=1 & `wcnt`!=0: decrement `wcnt`.
  - Else if `penable`=1 & `wcnt`==0, complete the transfer:
    - Write, no error: update memory.
    - Read, no error: `prdata` <= mem[index].
    - Error: memory unchanged, `prdata` <= 0, `pslverr` <= 1.
    - In all cases `pready` <= 1 and go to RESP.
- RESP: `pready` <= 0, `pslverr` <= 0, go to IDLE. `prdata` holds its last value.
- Write and read data are sampled on the completing edge. Address and control are also sampled then; the APB master holds them stable.
- Unknown state encoding returns to IDLE.

## Timing
- Reset values:
  - `prdata`=0, `pready`=0, `pslverr`=0.
  - State IDLE, `wcnt`=0.
  - All memory words are 0.
- Reset is sampled on every edge and overrides an in-flight transfer. A write interrupted by reset does not land.
- Cycle sequence, with T1 as the setup cycle:
  - T2 is the first `penable` cycle.
  - `pready` rises in cycle T2+WAIT_CYCLES+1 and stays high exactly one cycle.
  - Total transfer length = WAIT_CYCLES+3 cycles.
- Back-to-back transfers: a new setup may start in the cycle after `pready`=1. It is accepted from IDLE, giving zero idle cycles on the bus.
- Read-after-write to the same address returns the new data.

## Configuration
- `APB_MEM_PSTRB_EN` defined:
  - `pstrb` port exists.
  - Writes update only bytes whose strobe bit is 1.
  - `pstrb`=0 on a write completes OKAY with no change.
  - `pstrb` is ignored on reads.
- `APB_MEM_PSTRB_EN` undefined: no `pstrb` port, and every write updates the full word.

## Structure
- Package `apb_mem_pkg` holds:
  - State enum `apb_mem_state_t` (IDLE, WAIT, RESP).
  - Function `apb_mem_decode` (index + error flag).
  - Localparam helper for `OFS`.
- Sub-module `apb_mem_array` holds the storage:
  - Parameters DEPTH and DATA_W.
  - Synchronous clear.
  - Byte-enable write port.
  - Combinational read of the indexed word.

## Test plan
1. Reset, then defaults:
   - Assert `presetn`=0 for 2 cycles.
   - Then `prdata`=0, `pready`=0, `pslverr`=0.
   - A read of 0x10 returns 0.
2. Write then read, WAIT_CYCLES=0:
   - Write 0xDEADBEEF to 0x08, then read 0x08.
   - Read returns 0xDEADBEEF with `pslverr`=0.
   - Each transfer is 3 cycles with `pready` high for 1 cycle.
3. Wait states, WAIT_CYCLES=3:
   - `pready` rises 4 cycles after the first `penable` cycle.
   - `pready` remains 0 during the preceding `penable` cycles.
4. Errors (DEPTH=32):
   - Write 0x55 to 0x80: `pslverr`=1, no memory change.
   - Read 0x80: `prdata`=0, `pslverr`=1.
   - Read 0x02 (misaligned): `pslverr`=1.
5. Byte strobes (`APB_MEM_PSTRB_EN`):
   - Word 0x04 = 0x11223344.
   - Write 0xAABBCCDD with `pstrb`=4'b0101.
   - Read returns 0x11BB33DD.
6. Abort and reset mid-transfer:
   - Drop `psel` during a WAIT_CYCLES=3 write: no `pready`, memory unchanged.
   - Assert `presetn`=0 during a write access: `pready`=0 and the memory word stays 0.
